uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQUENCY, default 50000000, integer clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, integer line rate in bits/s.
REQ-003 Port clk_50mhz  input  1  sole clock; all logic on its rising edge.
REQ-004 Port rstN  input  1  reset, asynchronous assert, active-low.
REQ-005 Port rxd  input  1  asynchronous UART serial input, idle high.
REQ-006 Port rx_data  output  8  received byte, stable while rx_valid high.
REQ-007 Port rx_valid  output  1  byte available in output holding register.
REQ-008 Port rx_ready  input  1  consumer accepts; transfer occurs when rx_valid and rx_ready are both high on a clock edge.
REQ-009 Port frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-010 Port overrun  output  1  one-cycle pulse when a completed byte is dropped.
REQ-011 Port parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is not compiled in.
REQ-012 Port busy  output  1  high whenever the state machine is not IDLE.

Function
REQ-013 DIV = round(CLK_FREQUENCY/BAUD_RATE) (434 at defaults), HALF = DIV/2; elaboration shall fail if DIV < 4.
REQ-014 rxd passes through a 2-flop synchronizer with reset value 1; all decisions use the synchronized value (2-cycle input latency).
REQ-015 States: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-016 IDLE: a synchronized 1->0 transition loads the bit counter with HALF and enters START; a line held low never retriggers.
REQ-017 START: at counter expiry, sample 0 -> DATA with counter DIV; sample 1 -> IDLE silently (glitch reject, no error pulse).
REQ-018 DATA: sample every DIV cycles, 8 bits, LSB first, into a shift register; after bit 7 -> PARITY or STOP.
REQ-019 STOP: sample after DIV cycles; 1 -> deliver byte and return to IDLE; 0 -> frame_err pulse, byte discarded, return to IDLE.
REQ-020 Delivery: if rx_valid is low, or high with rx_ready high in the same cycle, load rx_data and set rx_valid on the next edge (no overrun).
REQ-021 Delivery while rx_valid high and rx_ready low: overrun pulse, new byte dropped, held rx_data unchanged.
REQ-022 rx_valid clears on the edge after acceptance unless a new byte is loaded on that same edge.
REQ-023 The receiver shall never stall; reception continues regardless of rx_valid.
REQ-024 Bit counter and bit index arithmetic uses $clog2(DIV+1) and 3-bit widths respectively; no wrap occurs inside a frame.

Reset
REQ-025 rstN low: state IDLE, synchronizer 1, rx_data 0x00, rx_valid 0, frame_err 0, overrun 0, parity_err 0, busy 0.
REQ-026 Reset asserted mid-frame aborts the frame with no output pulse; after release, reception restarts only on a fresh falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: one even-parity bit is expected after bit 7; PARITY samples it after DIV cycles; mismatch pulses parity_err in the cycle frame completes and the byte is discarded (not delivered, no overrun).
REQ-028 Macro UART_RX_PARITY_EN undefined: 8N1 framing, no PARITY state, parity_err tied 0.

Verification
REQ-029 8N1, defaults, send 0xA5 with rx_ready high -> rx_valid pulses once, rx_data 0xA5, frame_err/overrun 0.
REQ-030 Pulse rxd low for 100 cycles then high -> no rx_valid, no error, busy returns low within HALF+3 cycles.
REQ-031 Send 0x3C with stop bit forced low -> frame_err pulse exactly once, rx_valid stays 0, next byte 0x55 received correctly.
REQ-032 rx_ready low, send 0x11 then 0x22 -> overrun pulse once, rx_data remains 0x11; raise rx_ready -> transfer 0x11, rx_valid 0.
REQ-033 Assert rstN low during bit 4 of 0xFF, release, send 0x81 -> only 0x81 delivered.
REQ-034 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; parity bit 1 -> rx_data 0x07.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, 1 stop bit, valid/ready output holding register.
// Define UART_RX_PARITY_EN to expect one even-parity bit after bit 7.
module uart_rx #(
   parameter int CLK_FREQUENCY = 50000000,
   parameter int BAUD_RATE     = 115200
) (
   input  logic       clk_50mhz,
   input  logic       rstN,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err,
   output logic       busy
);

   localparam int DIV  = (CLK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV + 1);

   localparam logic [CW-1:0] DIV_C  = CW'(DIV);
   localparam logic [CW-1:0] HALF_C = CW'(HALF);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   if (DIV < 4) begin : g_div_check
      $error("uart_rx: CLK_FREQUENCY/BAUD_RATE must be at least 4");
   end

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e          r_state;
   logic            r_sync1;
   logic            r_sync2;
   logic            r_prev;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic [7:0]      r_data;
   logic            r_valid;
   logic            r_frame_err;
   logic            r_overrun;
   logic            w_tick;
   logic            w_par_bad;

`ifdef UART_RX_PARITY_EN
   logic            r_par;
   logic            r_parity_err;

   // Even parity: data bits plus parity bit must XOR to zero.
   assign w_par_bad  = ^{r_shift, r_par};
   assign parity_err = r_parity_err;
`else
   assign w_par_bad  = 1'b0;
   assign parity_err = 1'b0;
`endif

   assign w_tick    = (r_cnt == ONE_C);
   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = (r_state != StIdle);

   always_ff @(posedge clk_50mhz or negedge rstN) begin
      if (!rstN) begin
         r_state     <= StIdle;
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_prev      <= 1'b1;
         r_cnt       <= '0;
         r_bit       <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par        <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_sync1     <= rxd;
         r_sync2     <= r_sync1;
         r_prev      <= r_sync2;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         // A byte loaded below on the same edge overrides this clear.
         if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end

         // Bit timer runs continuously outside IDLE, reloading a full bit period on expiry.
         if (r_state != StIdle) begin
            r_cnt <= w_tick ? DIV_C : r_cnt - ONE_C;
         end

         case (r_state)
            StIdle: begin
               if (!r_sync2 && r_prev) begin
                  r_cnt   <= HALF_C;
                  r_state <= StStart;
               end
            end
            StStart: begin
               if (w_tick) begin
                  r_bit   <= '0;
                  r_state <= r_sync2 ? StIdle : StData;
               end
            end
            StData: begin
               if (w_tick) begin
                  r_shift <= {r_sync2, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= StParity;
`else
                     r_state <= StStop;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (w_tick) begin
                  r_par   <= r_sync2;
                  r_state <= StStop;
               end
            end
`endif
            StStop: begin
               if (w_tick) begin
                  r_state <= StIdle;
`ifdef UART_RX_PARITY_EN
                  r_parity_err <= w_par_bad;
`endif
                  if (!r_sync2) begin
                     r_frame_err <= 1'b1;
                  end else if (!w_par_bad) begin
                     if (!r_valid || rx_ready) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                     end else begin
                        r_overrun <= 1'b1;
                     end
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule
